// File: rtl/user_completer_if.sv
// AXI-Stream CQ/CC bundle between the PCIe core and the completer user logic.
// The master side is the core: it drives CQ and consumes CC.
interface user_completer_if #(
    parameter int unsigned C_DATA_WIDTH        = 128,
    parameter int unsigned AXI4_CQ_TUSER_WIDTH = 88,
    parameter int unsigned AXI4_CC_TUSER_WIDTH = 33
);
    localparam int unsigned KEEP_WIDTH = C_DATA_WIDTH / 32;

    logic [C_DATA_WIDTH-1:0]        m_axis_cq_tdata;
    logic [KEEP_WIDTH-1:0]          m_axis_cq_tkeep;
    logic                           m_axis_cq_tlast;
    logic                           m_axis_cq_tvalid;
    logic [AXI4_CQ_TUSER_WIDTH-1:0] m_axis_cq_tuser;
    logic                           m_axis_cq_tready;

    logic [C_DATA_WIDTH-1:0]        s_axis_cc_tdata;
    logic [KEEP_WIDTH-1:0]          s_axis_cc_tkeep;
    logic                           s_axis_cc_tlast;
    logic                           s_axis_cc_tvalid;
    logic [AXI4_CC_TUSER_WIDTH-1:0] s_axis_cc_tuser;
    logic                           s_axis_cc_tready;

    modport master (
        output m_axis_cq_tdata, m_axis_cq_tkeep, m_axis_cq_tlast, m_axis_cq_tvalid, m_axis_cq_tuser,
        input  m_axis_cq_tready,
        input  s_axis_cc_tdata, s_axis_cc_tkeep, s_axis_cc_tlast, s_axis_cc_tvalid, s_axis_cc_tuser,
        output s_axis_cc_tready
    );

    modport slave (
        input  m_axis_cq_tdata, m_axis_cq_tkeep, m_axis_cq_tlast, m_axis_cq_tvalid, m_axis_cq_tuser,
        output m_axis_cq_tready,
        output s_axis_cc_tdata, s_axis_cc_tkeep, s_axis_cc_tlast, s_axis_cc_tvalid, s_axis_cc_tuser,
        input  s_axis_cc_tready
    );
endinterface

// File: rtl/user_completer.sv
// Completer-side responder: single-DW MemRd/MemWr against a DW register file,
// unsupported requests drained and answered with UR when non-posted.
module user_completer #(
    parameter logic [15:0] COMPLETER_ID        = 16'h0000,
    parameter int unsigned MEM_DW              = 1024,
    parameter int unsigned AXI4_CQ_TUSER_WIDTH = 88,
    parameter int unsigned AXI4_CC_TUSER_WIDTH = 33,
    parameter int unsigned C_DATA_WIDTH        = 128,
    parameter int unsigned KEEP_WIDTH          = C_DATA_WIDTH / 32
) (
    input  logic            user_clk,
    input  logic            reset,
    user_completer_if.slave axis,
    output logic [15:0]     rd_count,
    output logic [15:0]     wr_count,
    output logic [15:0]     ur_count
);
    localparam int unsigned IDX_W      = $clog2(MEM_DW);
    localparam logic [3:0]  TYPE_MEMRD = 4'b0000;
    localparam logic [3:0]  TYPE_MEMWR = 4'b0001;

    typedef enum logic [2:0] {
        S_IDLE, S_WR_DATA, S_RD_MEM, S_CC_SEND, S_DRAIN
    } state_e;

    state_e                  state_q, state_d;
    logic                    cq_tready_q, cq_tready_d;
    logic                    cc_tvalid_q, cc_tvalid_d;
    logic                    cc_tlast_q, cc_tlast_d;
    logic [KEEP_WIDTH-1:0]   cc_tkeep_q, cc_tkeep_d;
    logic [C_DATA_WIDTH-1:0] cc_tdata_q, cc_tdata_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4:0]              lo_addr_q, lo_addr_d;
    logic [15:0]             req_id_q, req_id_d;
    logic [7:0]              tag_q, tag_d;
    logic [2:0]              tc_q, tc_d;
    logic [2:0]              attr_q, attr_d;
    logic [3:0]              first_be_q, first_be_d;
    logic                    ur_q, ur_d;
    logic                    np_q, np_d;
    logic [31:0]             rd_data_q, rd_data_d;
    logic [15:0]             rd_count_q, rd_count_d;
    logic [15:0]             wr_count_q, wr_count_d;
    logic [15:0]             ur_count_q, ur_count_d;

    logic [31:0] mem [MEM_DW];
    logic        mem_we_c;
    logic        cq_beat_c;
    logic [3:0]  req_type_c;
    logic        supported_c;
    logic        non_posted_c;
    logic        unused_bits;

    assign cq_beat_c    = axis.m_axis_cq_tvalid && cq_tready_q;
    assign req_type_c   = axis.m_axis_cq_tdata[78:75];
    assign supported_c  = ((req_type_c == TYPE_MEMRD) || (req_type_c == TYPE_MEMWR))
                          && (axis.m_axis_cq_tdata[74:64] == 11'd1)
                          && (axis.m_axis_cq_tdata[114:112] == 3'd0);
    // Posted types are MemWr and the message range 1100..1111.
    assign non_posted_c = (req_type_c != TYPE_MEMWR) && (req_type_c[3:2] != 2'b11);
    assign unused_bits  = ^{axis.m_axis_cq_tdata, axis.m_axis_cq_tkeep,
                            axis.m_axis_cq_tuser[AXI4_CQ_TUSER_WIDTH-1:4]};

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Next-state, descriptor capture, completion build and counters.
    always_comb begin
        state_d    = state_q;
        cc_tvalid_d = cc_tvalid_q;
        cc_tlast_d = cc_tlast_q;
        cc_tkeep_d = cc_tkeep_q;
        cc_tdata_d = cc_tdata_q;
        idx_d      = idx_q;
        lo_addr_d  = lo_addr_q;
        req_id_d   = req_id_q;
        tag_d      = tag_q;
        tc_d       = tc_q;
        attr_d     = attr_q;
        first_be_d = first_be_q;
        ur_d       = ur_q;
        np_d       = np_q;
        rd_data_d  = rd_data_q;
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        ur_count_d = ur_count_q;
        mem_we_c   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cq_beat_c) begin
                    idx_d      = axis.m_axis_cq_tdata[IDX_W+1:2];
                    lo_addr_d  = axis.m_axis_cq_tdata[6:2];
                    req_id_d   = axis.m_axis_cq_tdata[95:80];
                    tag_d      = axis.m_axis_cq_tdata[103:96];
                    tc_d       = axis.m_axis_cq_tdata[123:121];
                    attr_d     = axis.m_axis_cq_tdata[126:124];
                    first_be_d = axis.m_axis_cq_tuser[3:0];
                    ur_d       = !supported_c;
                    np_d       = non_posted_c;
                    if (supported_c)
                        state_d = (req_type_c == TYPE_MEMWR) ? S_WR_DATA : S_RD_MEM;
                    else if (!axis.m_axis_cq_tlast)
                        state_d = S_DRAIN;
                    else if (non_posted_c)
                        state_d = S_CC_SEND;
                end
            end
            S_WR_DATA: begin
                if (cq_beat_c) begin
                    mem_we_c   = 1'b1;
                    wr_count_d = sat_inc(wr_count_q);
                    state_d    = axis.m_axis_cq_tlast ? S_IDLE : S_DRAIN;
                end
            end
            S_RD_MEM: begin
                rd_data_d = mem[idx_q];
                state_d   = S_CC_SEND;
            end
            S_CC_SEND: begin
                if (!cc_tvalid_q) begin
                    cc_tdata_d          = '0;
                    cc_tdata_d[6:0]     = {lo_addr_q, 2'b00};
                    cc_tdata_d[28:16]   = ur_q ? 13'd0 : 13'd4;
                    cc_tdata_d[42:32]   = ur_q ? 11'd0 : 11'd1;
                    cc_tdata_d[45:43]   = ur_q ? 3'b001 : 3'b000;
                    cc_tdata_d[63:48]   = req_id_q;
                    cc_tdata_d[71:64]   = tag_q;
                    cc_tdata_d[87:72]   = COMPLETER_ID;
                    cc_tdata_d[91:89]   = tc_q;
                    cc_tdata_d[94:92]   = attr_q;
                    cc_tdata_d[127:96]  = ur_q ? 32'd0 : rd_data_q;
                    cc_tvalid_d         = 1'b1;
                    cc_tlast_d          = 1'b1;
                    cc_tkeep_d          = '1;
                end else if (axis.s_axis_cc_tready) begin
                    cc_tvalid_d = 1'b0;
                    cc_tlast_d  = 1'b0;
                    cc_tkeep_d  = '0;
                    cc_tdata_d  = '0;
                    if (ur_q) ur_count_d = sat_inc(ur_count_q);
                    else      rd_count_d = sat_inc(rd_count_q);
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (cq_beat_c && axis.m_axis_cq_tlast)
                    state_d = (ur_q && np_q) ? S_CC_SEND : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        cq_tready_d = (state_d == S_IDLE) || (state_d == S_WR_DATA) || (state_d == S_DRAIN);
    end

    always_ff @(posedge user_clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cq_tready_q <= 1'b0;
            cc_tvalid_q <= 1'b0;
            cc_tlast_q  <= 1'b0;
            cc_tkeep_q  <= '0;
            cc_tdata_q  <= '0;
            idx_q       <= '0;
            lo_addr_q   <= '0;
            req_id_q    <= '0;
            tag_q       <= '0;
            tc_q        <= '0;
            attr_q      <= '0;
            first_be_q  <= '0;
            ur_q        <= 1'b0;
            np_q        <= 1'b0;
            rd_data_q   <= '0;
            rd_count_q  <= '0;
            wr_count_q  <= '0;
            ur_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            cq_tready_q <= cq_tready_d;
            cc_tvalid_q <= cc_tvalid_d;
            cc_tlast_q  <= cc_tlast_d;
            cc_tkeep_q  <= cc_tkeep_d;
            cc_tdata_q  <= cc_tdata_d;
            idx_q       <= idx_d;
            lo_addr_q   <= lo_addr_d;
            req_id_q    <= req_id_d;
            tag_q       <= tag_d;
            tc_q        <= tc_d;
            attr_q      <= attr_d;
            first_be_q  <= first_be_d;
            ur_q        <= ur_d;
            np_q        <= np_d;
            rd_data_q   <= rd_data_d;
            rd_count_q  <= rd_count_d;
            wr_count_q  <= wr_count_d;
            ur_count_q  <= ur_count_d;
        end
    end

    // Register file is not reset; byte lanes gated by the captured first_be.
    always_ff @(posedge user_clk) begin
        if (mem_we_c) begin
            for (int b = 0; b < 4; b++) begin
                if (first_be_q[b]) mem[idx_q][b*8 +: 8] <= axis.m_axis_cq_tdata[b*8 +: 8];
            end
        end
    end

    assign axis.m_axis_cq_tready = cq_tready_q;
    assign axis.s_axis_cc_tvalid = cc_tvalid_q;
    assign axis.s_axis_cc_tlast  = cc_tlast_q;
    assign axis.s_axis_cc_tkeep  = cc_tkeep_q;
    assign axis.s_axis_cc_tdata  = cc_tdata_q;
    assign axis.s_axis_cc_tuser  = AXI4_CC_TUSER_WIDTH'(0);
    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
    assign ur_count = ur_count_q;
endmodule

// File: tb/tb_user_completer.sv
// Directed bench for user_completer: writes, masked writes, reads, backpressure,
// UR completions, drained posted requests, address aliasing and reset mid-completion.
module tb_user_completer;
    localparam logic [15:0] CPL_ID  = 16'h0100;
    localparam logic [15:0] REQ_ID  = 16'hABCD;
    localparam logic [2:0]  TC      = 3'd2;
    localparam logic [2:0]  ATTR    = 3'd5;
    localparam int unsigned MEM_DW  = 1024;
    localparam logic [3:0]  T_MEMRD = 4'b0000;
    localparam logic [3:0]  T_MEMWR = 4'b0001;
    localparam logic [3:0]  T_MSG   = 4'b1100;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] rd_count, wr_count, ur_count;
    int          n_vec  = 0;
    int          n_fail = 0;

    user_completer_if axis ();

    user_completer #(.COMPLETER_ID(CPL_ID), .MEM_DW(MEM_DW)) dut (
        .user_clk (clk),
        .reset    (rst),
        .axis     (axis),
        .rd_count (rd_count),
        .wr_count (wr_count),
        .ur_count (ur_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mk_desc(input logic [63:0] addr, input logic [10:0] dwc,
                                             input logic [3:0] typ, input logic [7:0] tag,
                                             input logic [2:0] bar);
        logic [127:0] d;
        d            = '0;
        d[63:2]      = addr[63:2];
        d[74:64]     = dwc;
        d[78:75]     = typ;
        d[95:80]     = REQ_ID;
        d[103:96]    = tag;
        d[114:112]   = bar;
        d[123:121]   = TC;
        d[126:124]   = ATTR;
        return d;
    endfunction

    // Present one CQ beat and hold it until the DUT takes it (bounded).
    task automatic send_beat(input logic [127:0] d, input logic [3:0] be,
                             input logic sop, input logic last);
        logic        done;
        logic [87:0] u;
        done = 1'b0;
        u = '0;
        u[3:0] = be;
        u[40]  = sop;
        axis.m_axis_cq_tdata  = d;
        axis.m_axis_cq_tkeep  = 4'hF;
        axis.m_axis_cq_tuser  = u;
        axis.m_axis_cq_tlast  = last;
        axis.m_axis_cq_tvalid = 1'b1;
        for (int i = 0; i < 32 && !done; i++) begin
            if (axis.m_axis_cq_tready) done = 1'b1;
            @(posedge clk); #1;
        end
        axis.m_axis_cq_tvalid = 1'b0;
        axis.m_axis_cq_tlast  = 1'b0;
        chk("cq_beat_accepted", {127'd0, done}, 128'd1);
    endtask

    task automatic write_dw(input logic [63:0] addr, input logic [31:0] data,
                            input logic [3:0] be, input logic [7:0] tag);
        send_beat(mk_desc(addr, 11'd1, T_MEMWR, tag, 3'd0), be, 1'b1, 1'b0);
        send_beat({96'd0, data}, 4'h0, 1'b0, 1'b1);
    endtask

    task automatic get_cpl(output logic [127:0] d);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (axis.s_axis_cc_tvalid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("cc_tvalid_seen", {127'd0, ok}, 128'd1);
        d = axis.s_axis_cc_tdata;
    endtask

    task automatic no_cc_for(input int cycles, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (axis.s_axis_cc_tvalid !== 1'b0) seen = 1'b1;
        end
        chk(tag, {127'd0, seen}, 128'd0);
    endtask

    initial begin
        logic [127:0] d;
        logic [127:0] d0;
        logic         stable;

        rst = 1'b1;
        axis.m_axis_cq_tdata  = '0;
        axis.m_axis_cq_tkeep  = '0;
        axis.m_axis_cq_tlast  = 1'b0;
        axis.m_axis_cq_tvalid = 1'b0;
        axis.m_axis_cq_tuser  = '0;
        axis.s_axis_cc_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cq_tready", axis.m_axis_cq_tready, 0);
        chk("rst_cc_ctrl", {axis.s_axis_cc_tvalid, axis.s_axis_cc_tlast, axis.s_axis_cc_tkeep}, 0);
        chk("rst_cc_tdata", axis.s_axis_cc_tdata, 0);
        chk("rst_counters", {rd_count, wr_count, ur_count}, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("cq_tready_after_rst", axis.m_axis_cq_tready, 1);

        // Full-DW write then read back with exact latency.
        write_dw(64'h10, 32'hDEADBEEF, 4'hF, 8'd5);
        chk("wr1_count", wr_count, 1);
        chk("wr1_no_cc", axis.s_axis_cc_tvalid, 0);
        send_beat(mk_desc(64'h10, 11'd1, T_MEMRD, 8'd6, 3'd0), 4'hF, 1'b1, 1'b1);
        chk("rd1_n0_ready_valid", {axis.m_axis_cq_tready, axis.s_axis_cc_tvalid}, 2'b00);
        @(posedge clk); #1;
        chk("rd1_n1_tvalid", axis.s_axis_cc_tvalid, 0);
        @(posedge clk); #1;
        chk("rd1_n2_tvalid", axis.s_axis_cc_tvalid, 1);
        d = axis.s_axis_cc_tdata;
        chk("rd1_tdata", d, 128'hDEADBEEF_54010006_ABCD0001_00040010);
        chk("rd1_keep_last", {axis.s_axis_cc_tkeep, axis.s_axis_cc_tlast}, 5'b11111);
        chk("rd1_status", d[45:43], 3'b000);
        chk("rd1_dwcount", d[42:32], 11'd1);
        chk("rd1_bytecount", d[28:16], 13'd4);
        chk("rd1_lo_addr", d[6:0], 7'h10);
        chk("rd1_tag", d[71:64], 8'd6);
        chk("rd1_cc_tuser", axis.s_axis_cc_tuser, 0);
        @(posedge clk); #1;
        chk("rd1_done", axis.s_axis_cc_tvalid, 0);
        chk("rd1_counts", {rd_count, wr_count, ur_count}, {16'd1, 16'd1, 16'd0});

        // Byte-masked write over a pre-filled DW.
        write_dw(64'h20, 32'hDEADBEEF, 4'hF, 8'd7);
        write_dw(64'h20, 32'h11223344, 4'b0101, 8'd8);
        send_beat(mk_desc(64'h20, 11'd1, T_MEMRD, 8'h0A, 3'd0), 4'hF, 1'b1, 1'b1);
        get_cpl(d);
        chk("mask_tdata", d, 128'hDE22BE44_5401000A_ABCD0001_00040020);
        @(posedge clk); #1;
        chk("mask_counts", {rd_count, wr_count, ur_count}, {16'd2, 16'd3, 16'd0});

        // CC backpressure: completion held steady, CQ blocked.
        axis.s_axis_cc_tready = 1'b0;
        send_beat(mk_desc(64'h10, 11'd1, T_MEMRD, 8'd7, 3'd0), 4'hF, 1'b1, 1'b1);
        get_cpl(d0);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (!(axis.s_axis_cc_tvalid === 1'b1 && axis.s_axis_cc_tdata === d0
                  && axis.m_axis_cq_tready === 1'b0)) stable = 1'b0;
        end
        chk("bp_hold", stable, 1);
        chk("bp_data_tag", {d0[127:96], d0[71:64]}, {32'hDEADBEEF, 8'd7});
        axis.s_axis_cc_tready = 1'b1;
        @(posedge clk); #1;
        chk("bp_done", {axis.s_axis_cc_tvalid, rd_count}, {1'b0, 16'd3});

        // MemRd with dword count 2 gets UR.
        send_beat(mk_desc(64'h10, 11'd2, T_MEMRD, 8'd9, 3'd0), 4'hF, 1'b1, 1'b1);
        get_cpl(d);
        chk("ur_tdata", d, 128'h00000000_54010009_ABCD0800_00000010);
        chk("ur_fields", {d[45:43], d[42:32], d[28:16], d[71:64]}, {3'b001, 11'd0, 13'd0, 8'd9});
        @(posedge clk); #1;
        chk("ur_counts", {rd_count, wr_count, ur_count}, {16'd3, 16'd3, 16'd1});

        // Multi-DW MemWr: drained, no completion, memory untouched.
        send_beat(mk_desc(64'h10, 11'd4, T_MEMWR, 8'h0B, 3'd0), 4'hF, 1'b1, 1'b0);
        send_beat({4{32'h55555555}}, 4'h0, 1'b0, 1'b0);
        send_beat({4{32'h66666666}}, 4'h0, 1'b0, 1'b1);
        no_cc_for(4, "drain_no_cc");
        chk("drain_counts", {rd_count, wr_count, ur_count}, {16'd3, 16'd3, 16'd1});
        send_beat(mk_desc(64'h10, 11'd1, T_MEMRD, 8'h0E, 3'd0), 4'hF, 1'b1, 1'b1);
        get_cpl(d);
        chk("drain_mem_intact", d[127:96], 32'hDEADBEEF);
        @(posedge clk); #1;
        chk("drain_next_served", rd_count, 16'd4);

        // Upper address bits alias onto the register file.
        write_dw(64'(MEM_DW * 4 + 8), 32'hCAFEF00D, 4'hF, 8'h0F);
        send_beat(mk_desc(64'h8, 11'd1, T_MEMRD, 8'h0C, 3'd0), 4'hF, 1'b1, 1'b1);
        get_cpl(d);
        chk("alias_tdata", d, 128'hCAFEF00D_5401000C_ABCD0001_00040008);
        @(posedge clk); #1;
        chk("alias_counts", {rd_count, wr_count, ur_count}, {16'd5, 16'd4, 16'd1});

        // Posted message: unsupported but no completion owed.
        send_beat(mk_desc(64'h0, 11'd0, T_MSG, 8'h10, 3'd0), 4'h0, 1'b1, 1'b1);
        no_cc_for(4, "msg_no_cc");
        chk("msg_counts", {ur_count, 15'd0, axis.m_axis_cq_tready}, {16'd1, 16'd1});

        // Non-zero BAR MemRd spanning two beats: drained then UR.
        send_beat(mk_desc(64'h40, 11'd1, T_MEMRD, 8'h0D, 3'd1), 4'hF, 1'b1, 1'b0);
        send_beat(128'd0, 4'h0, 1'b0, 1'b1);
        get_cpl(d);
        chk("bar_ur_tdata", d, 128'h00000000_5401000D_ABCD0800_00000040);
        @(posedge clk); #1;
        chk("bar_ur_count", ur_count, 16'd2);

        // Reset while a completion is stalled.
        axis.s_axis_cc_tready = 1'b0;
        send_beat(mk_desc(64'h8, 11'd1, T_MEMRD, 8'h11, 3'd0), 4'hF, 1'b1, 1'b1);
        get_cpl(d);
        rst = 1'b1;
        #1;
        chk("rst_async_tvalid", axis.s_axis_cc_tvalid, 0);
        chk("rst_async_counters", {rd_count, wr_count, ur_count}, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        axis.s_axis_cc_tready = 1'b1;
        no_cc_for(6, "rst_no_stale_cc");
        chk("rst_cq_tready_back", axis.m_axis_cq_tready, 1);
        send_beat(mk_desc(64'h8, 11'd1, T_MEMRD, 8'h12, 3'd0), 4'hF, 1'b1, 1'b1);
        get_cpl(d);
        chk("post_rst_read", {d[127:96], d[71:64]}, {32'hCAFEF00D, 8'h12});
        @(posedge clk); #1;
        chk("post_rst_counts", {rd_count, wr_count, ur_count}, {16'd1, 16'd0, 16'd0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
